// File: rtl/rf_alu_pipe.sv
// Register file with write-through bypass, ID/EXE pipeline register,
// 8-op ALU and C/Z/N status register.
module rf_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 8,
    parameter int INS_W  = ADDR_W + IMM_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [INS_W-1:0]  Ins,
    input  logic [DATA_W-1:0] WBData,
    input  logic [DATA_W-1:0] MEMData,
    input  logic              WBRF,
    input  logic              WBresource,
    input  logic              RBresource,
    input  logic              OprandB,
    input  logic              LI,
    input  logic              Buff_IDEXE,
    input  logic [2:0]        ALUop,
    input  logic              Flag,
    output logic [DATA_W-1:0] Rm,
    output logic [DATA_W-1:0] Rd,
    output logic [DATA_W-1:0] Sum,
    output logic [DATA_W-1:0] OutR,
    output logic [DATA_W-1:0] LI_EXE,
    output logic              EXE_valid,
    output logic              C,
    output logic              Z,
    output logic              N
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> IMM_W;

    logic [ADDR_W-1:0] rd_a, rm_a, rn_a, rb_a;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] wdata, imm_ext, li_val;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] outr_q, outr_d, li_q, li_d;
    logic [2:0]        op_q, op_d;
    logic              flag_q, flag_d, valid_q, valid_d;
    logic              c_q, c_d, z_q, z_d, n_q, n_d;

    logic [DATA_W:0]   ea, eb, ci, ext;

    // ID: decode, bypassed reads, load-immediate build
    always_comb begin
        rd_a    = Ins[INS_W-1 -: ADDR_W];
        rm_a    = Ins[IMM_W-1 -: ADDR_W];
        rn_a    = Ins[IMM_W-1-ADDR_W -: ADDR_W];
        imm     = Ins[IMM_W-1:0];
        rb_a    = RBresource ? rd_a : rn_a;
        wdata   = WBresource ? MEMData : WBData;
        Rm      = (WBRF && rd_a == rm_a) ? wdata : rf_q[rm_a];
        Rd      = (WBRF && rd_a == rb_a) ? wdata : rf_q[rb_a];
        imm_ext = DATA_W'(imm);
        if (LI)
            li_val = (imm_ext << (DATA_W - IMM_W)) | (Rd & LO_MASK);
        else
            li_val = imm_ext;
    end

    always_comb begin
        rf_d = rf_q;
        if (WBRF)
            rf_d[rd_a] = wdata;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        outr_d  = outr_q;
        li_d    = li_q;
        op_d    = op_q;
        flag_d  = flag_q;
        valid_d = 1'b0;
        if (Buff_IDEXE) begin
            a_d     = Rm;
            b_d     = OprandB ? imm_ext : Rd;
            outr_d  = Rd;
            li_d    = li_val;
            op_d    = ALUop;
            flag_d  = Flag;
            valid_d = 1'b1;
        end
    end

    // EXE: subtract forms invert B; carry-in picks 0, 1 or PSW.C
    always_comb begin
        ea  = {1'b0, a_q};
        eb  = op_q[1] ? {1'b0, ~b_q} : {1'b0, b_q};
        ci  = '0;
        ext = '0;
        unique case (op_q)
            3'b000: ci = '0;
            3'b001: ci = (DATA_W+1)'(c_q);
            3'b010: ci = (DATA_W+1)'(1);
            3'b011: ci = (DATA_W+1)'(c_q);
            default: ci = '0;
        endcase
        unique case (op_q)
            3'b100:  ext = {1'b0, a_q & b_q};
            3'b101:  ext = {1'b0, a_q | b_q};
            3'b110:  ext = {1'b0, a_q ^ b_q};
            3'b111:  ext = {1'b0, b_q};
            default: ext = ea + eb + ci;
        endcase
        Sum = ext[DATA_W-1:0];
        c_d = c_q;
        z_d = z_q;
        n_d = n_q;
        if (valid_q && flag_q) begin
            z_d = (Sum == '0);
            n_d = Sum[DATA_W-1];
            if (!op_q[2])
                c_d = ext[DATA_W];
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++)
                rf_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            outr_q  <= '0;
            li_q    <= '0;
            op_q    <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            outr_q  <= outr_d;
            li_q    <= li_d;
            op_q    <= op_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign OutR      = outr_q;
    assign LI_EXE    = li_q;
    assign EXE_valid = valid_q;
    assign C         = c_q;
    assign Z         = z_q;
    assign N         = n_q;

endmodule
